// File: rtl/instr_cache_if.sv
// Fetch-side and backing-memory signals of the instruction cache.
// slave = cache view, master = core/memory view.
interface instr_cache_if;
  logic [31:0] pc_f_i;
  logic        ic_invalidate_i;
  logic [31:0] instr_f_o;
  logic        instr_hit_f_o;
  logic        ic_repl_permit_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;

  modport slave (
    input  pc_f_i,
    input  ic_invalidate_i,
    input  mem_ready_i,
    input  mem_rdata_i,
    output instr_f_o,
    output instr_hit_f_o,
    output ic_repl_permit_o,
    output mem_req_o,
    output mem_addr_o,
    output hit_count_o,
    output miss_count_o
  );

  modport master (
    output pc_f_i,
    output ic_invalidate_i,
    output mem_ready_i,
    output mem_rdata_i,
    input  instr_f_o,
    input  instr_hit_f_o,
    input  ic_repl_permit_o,
    input  mem_req_o,
    input  mem_addr_o,
    input  hit_count_o,
    input  miss_count_o
  );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped read-only I-cache with word-wide line fill.
// Define IC_STATS_EN to get hit/miss counters.
module instr_cache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_SETS   = 64
) (
  input logic clk_i,
  input logic reset_i,
  instr_cache_if.slave bus
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int SW = $clog2(NUM_SETS);
  localparam int LW = 30 - OW;
  localparam int TW = LW - SW;
  localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   data_q [NUM_SETS][LINE_WORDS];
  logic [TW-1:0] tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;

  logic [OW-1:0] beat_q;
  logic [LW-1:0] line_q;
  logic          poison_q;

  logic [OW-1:0] pc_off;
  logic [SW-1:0] pc_set;
  logic [TW-1:0] pc_tag;
  logic [SW-1:0] fill_set;
  logic [TW-1:0] fill_tag;
  logic          hit;
  logic          start;
  logic          accept;
  logic          last;
  logic          unused_pc;

  assign pc_off    = bus.pc_f_i[OW+1:2];
  assign pc_set    = bus.pc_f_i[OW+SW+1:OW+2];
  assign pc_tag    = bus.pc_f_i[31:OW+SW+2];
  assign fill_set  = line_q[SW-1:0];
  assign fill_tag  = line_q[LW-1:SW];
  assign unused_pc = ^bus.pc_f_i[1:0];

  assign hit = (state == IDLE) && valid_q[pc_set]
             && (tag_q[pc_set] == pc_tag);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!hit && !bus.ic_invalidate_i) begin
          state_nxt = FILL;
          start     = 1'b1;
        end
      end
      FILL: begin
        if (bus.mem_ready_i) begin
          accept = 1'b1;
          if (beat_q == LAST) begin
            last      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      valid_q  <= '0;
      beat_q   <= '0;
      line_q   <= '0;
      poison_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        line_q   <= bus.pc_f_i[31:OW+2];
        beat_q   <= '0;
        poison_q <= 1'b0;
      end
      if (accept) beat_q <= beat_q + 1'b1;
      if (state == FILL && bus.ic_invalidate_i) poison_q <= 1'b1;
      if (bus.ic_invalidate_i) valid_q <= '0;
      // an invalidate seen at any point of the fill leaves the line invalid
      if (last)
        valid_q[fill_set] <= !(poison_q || bus.ic_invalidate_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && accept) data_q[fill_set][beat_q] <= bus.mem_rdata_i;
    if (!reset_i && last) tag_q[fill_set] <= fill_tag;
  end

  assign bus.instr_f_o        = hit ? data_q[pc_set][pc_off] : 32'h0000_0013;
  assign bus.instr_hit_f_o    = hit;
  assign bus.ic_repl_permit_o = (state == IDLE);
  assign bus.mem_req_o        = (state == FILL);
  assign bus.mem_addr_o       = (state == FILL) ? {line_q, beat_q, 2'b00} : '0;

`ifdef IC_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (hit)   hits_q   <= hits_q + 32'd1;
      if (start) misses_q <= misses_q + 32'd1;
    end
  end

  assign bus.hit_count_o  = hits_q;
  assign bus.miss_count_o = misses_q;
`else
  assign bus.hit_count_o  = '0;
  assign bus.miss_count_o = '0;
`endif

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache that answers the core's fetch-stage interface. It returns `instr_f`, `instr_hit_f` and `ic_repl_permit` for the current `pc_f`. On a miss it runs a line-fill state machine against a word-wide backing-memory handshake and installs the line. It sits between `pipelined_riscv_core` and main memory; the hazard unit stalls fetch while `instr_hit_f` is low.

## Interface
- `LINE_WORDS`, 4: 32-bit words per line; power of two, 2 to 16.
- `NUM_SETS`, 64: number of lines; power of two, 4 to 1024.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i` input 1: clock.
- `reset_i` input 1: synchronous, active-high reset.
- `pc_f_i` input 32: fetch address; bits [1:0] ignored.
- `ic_invalidate_i` input 1: invalidate all lines (fence.i).
- `instr_f_o` output 32: instruction at `pc_f_i`.
- `instr_hit_f_o` output 1: `instr_f_o` is valid this cycle.
- `ic_repl_permit_o` output 1: no fill in flight; redirect or flush may be taken.
- `mem_req_o` output 1: beat request to backing memory.
- `mem_addr_o` output 32: word-aligned beat address.
- `mem_ready_i` input 1: beat accepted; `mem_rdata_i` valid this cycle.
- `mem_rdata_i` input 32: beat data.
- `hit_count_o` output 32: hit counter; see Configuration.
- `miss_count_o` output 32: miss counter; see Configuration.

## Operation
- Address split: word offset is `pc[2+OW-1:2]` with OW = log2(LINE_WORDS). Set index is the next log2(NUM_SETS) bits. Tag is the remaining upper bits.
- Storage:
  - data array: NUM_SETS×LINE_WORDS×32, read asynchronously.
  - tag array: one entry per set.
  - valid bits: one per set.
- Lookup is combinational: hit = valid[set] && tag[set]==tag(pc_f_i) && state==IDLE.
  - On hit, `instr_f_o` = stored word.
  - Otherwise `instr_f_o` = 32'h0000_0013 (NOP).
- FSM states: IDLE, FILL.
  - IDLE → FILL when there is no hit and `ic_invalidate_i` is low.
    - Latch line base = {pc_f_i[31:2+OW], OW'b0, 2'b0}.
    - Clear the beat counter.
  - FILL: `mem_req_o`=1, `mem_addr_o` = base + 4×beat.
    - Each cycle with `mem_ready_i`=1: write `mem_rdata_i` into data[set][beat] and increment beat.
    - On the last beat (beat==LINE_WORDS-1), write the latched tag, set valid, and return to IDLE.
- `ic_repl_permit_o` = (state==IDLE).
- Redirect mid-fill (pc_f_i changes): the fill completes to the latched address. After returning to IDLE, lookup uses the new pc, and may miss again.
- `ic_invalidate_i`:
  - In IDLE: clears all valid bits at the clock edge. No fill starts that cycle.
  - In FILL: the fill finishes, but the line is installed with valid=0. All other valid bits clear at the same edge.
- Reset, at any point including mid-fill:
  - state = IDLE, all valid bits = 0, beat = 0.
  - `mem_req_o`=0, `mem_addr_o`=0, counters = 0.
  - Data and tag arrays are not reset.
- Reset values of outputs:
  - `instr_f_o`=32'h13, `instr_hit_f_o`=0.
  - `ic_repl_permit_o`=1, `mem_req_o`=0, `mem_addr_o`=0.
  - `hit_count_o`=0, `miss_count_o`=0.

## Timing
- Hit: zero latency. Outputs are valid in the same cycle as `pc_f_i`.
- Miss detected in cycle t: `mem_req_o` is high from t+1. It is registered and never asserted in IDLE.
- With `mem_ready_i` held high, beats are accepted in t+1..t+LINE_WORDS. The line is written at the end of cycle t+LINE_WORDS, and `instr_hit_f_o`=1 in t+LINE_WORDS+1. Penalty = LINE_WORDS+1 cycles.
- `mem_ready_i` low stalls the beat: `mem_addr_o` and the beat counter hold.
- `mem_req_o` drops in the cycle after the last accepted beat.
- `mem_rdata_i` is sampled only when `mem_req_o && mem_ready_i`.

## Configuration
- `IC_STATS_EN` defined:
  - `miss_count_o` increments on every IDLE→FILL transition.
  - `hit_count_o` increments on every cycle with `instr_hit_f_o`=1.
  - Both counters wrap at 2^32.
- `IC_STATS_EN` undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Cold miss:
  - Stimulus: after reset, pc_f_i=0x100, `mem_ready_i`=1, memory returns word = address.
  - Required: `mem_addr_o` is 0x100, 0x104, 0x108, 0x10C in consecutive cycles; hit in cycle 6 with `instr_f_o`=0x100.
- Hits within the line:
  - Stimulus: pc 0x104, 0x108, 0x10C after the fill.
  - Required: hit the same cycle with data 0x104, 0x108, 0x10C; `mem_req_o` stays 0.
- Conflict eviction:
  - Stimulus: fill 0x100, then pc=0x100+16×NUM_SETS (same set, different tag), then back to 0x100.
  - Required: each access misses and refills; `miss_count_o`=3 with `IC_STATS_EN`.
- Backpressure and redirect:
  - Stimulus: miss at 0x200; `mem_ready_i` toggles 1,0,0,1,1,1; pc changes to 0x300 mid-fill.
  - Required: `mem_addr_o` holds during the ready=0 cycles; line 0x200 is installed; `ic_repl_permit_o`=0 throughout the fill; a new fill for 0x300 starts the cycle after returning to IDLE.
- Invalidate:
  - Stimulus: `ic_invalidate_i` pulses during a FILL for 0x400; then pc=0x400 and pc=0x100.
  - Required: both miss.
- Reset mid-fill:
  - Stimulus: `reset_i` asserted on the second beat.
  - Required: `mem_req_o`=0 on the next cycle, `instr_hit_f_o`=0 for pc 0x100, and counters are 0.
